// File: rtl/dmg_lcd_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : dmg_lcd_capture_if
// Description : VRAM write bus carrying captured DMG LCD pixels.
//               The master side drives the bus and the slave side receives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmg_lcd_capture_if;
    logic [15:0] vram_addr;   // [15:8] line, [7:0] pixel
    logic [1:0]  vram_data;   // pixel shade
    logic        vram_we;     // one-cycle write strobe

    modport master (
        output vram_addr,
        output vram_data,
        output vram_we
    );

    modport slave (
        input  vram_addr,
        input  vram_data,
        input  vram_we
    );
endinterface
`default_nettype wire

// File: rtl/dmg_lcd_capture.sv
`default_nettype none
// ============================================================================
// Module      : dmg_lcd_capture
// Description : Captures the Game Boy DMG LCD pixel stream into VRAM writes.
//               All LCD signals are asynchronous. They are synchronized into
//               clk_8m and edge-detected, and they drive an x/y address
//               generator that is gated by a frame-lock state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module dmg_lcd_capture #(
    parameter int H_PIXELS       = 160,
    parameter int V_LINES        = 144,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter bit INVERT_DATA    = 1'b0
) (
    input  wire                       clk_8m,
    input  wire                       rst,
    input  wire                       lcd_clk,
    input  wire                       lcd_hsync,
    input  wire                       lcd_vsync,
    input  wire                       lcd_d0,
    input  wire                       lcd_d1,
    dmg_lcd_capture_if.master         vram,
    output logic                      frame_start,
    output logic                      locked,
    output logic                      overrun
);

    // Bit positions inside the synchronizer vectors.
    localparam int c_B_CLK = 4;
    localparam int c_B_HS  = 3;
    localparam int c_B_VS  = 2;

    localparam logic [7:0] c_H_MAX  = 8'(H_PIXELS);
    localparam logic [7:0] c_Y_LAST = 8'(V_LINES - 1);

    localparam int                c_TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_CYCLES);

    localparam logic [0:0] c_ST_WAIT_FRAME = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE     = 1'b1;

    logic [4:0]        w_async;
    logic [4:0]        r_sync1;
    logic [4:0]        r_sync2;
    logic              r_clk_s3;
    logic              r_hs_s3;

    logic              w_pix_fall;
    logic              w_hs_rise;
    logic              w_vs;
    logic [1:0]        w_pix;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;

    logic [7:0]        r_x;
    logic [7:0]        r_y;
    logic              r_inhibit;
    logic [c_TO_W-1:0] r_timeout;
    logic              w_timeout_hit;

    assign w_async = {lcd_clk, lcd_hsync, lcd_vsync, lcd_d1, lcd_d0};

    // Edge detection compares the second synchronizer stage with the third
    // flop. Data and vsync are read from the same second stage, so they line
    // up with the edge that was detected.
    assign w_pix_fall    = r_clk_s3 & ~r_sync2[c_B_CLK];
    assign w_hs_rise     = ~r_hs_s3 & r_sync2[c_B_HS];
    assign w_vs          = r_sync2[c_B_VS];
    assign w_pix         = INVERT_DATA ? ~r_sync2[1:0] : r_sync2[1:0];
    assign w_timeout_hit = (r_timeout >= c_TO_LIMIT);
    assign locked        = (r_state == c_ST_ACTIVE);

    // Two-flop synchronizers on every LCD input, plus an edge flop on lcd_clk and hsync.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_clk_s3 <= 1'b0;
            r_hs_s3  <= 1'b0;
        end else begin
            r_sync1  <= w_async;
            r_sync2  <= r_sync1;
            r_clk_s3 <= r_sync2[c_B_CLK];
            r_hs_s3  <= r_sync2[c_B_HS];
        end
    end

    // Lock state register.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            r_state <= c_ST_WAIT_FRAME;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lock on a vsync-marked hsync edge, and drop lock after a long hsync silence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_WAIT_FRAME: begin
                if (w_hs_rise && w_vs) begin
                    w_state_next = c_ST_ACTIVE;
                end
            end
            c_ST_ACTIVE: begin
                if (!w_hs_rise && w_timeout_hit) begin
                    w_state_next = c_ST_WAIT_FRAME;
                end
            end
            default: w_state_next = c_ST_WAIT_FRAME;
        endcase
    end

    // Hsync watchdog. It saturates at the limit so that it never wraps while unlocked.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            r_timeout <= '0;
        end else if (w_hs_rise) begin
            r_timeout <= '0;
        end else if (!w_timeout_hit) begin
            r_timeout <= r_timeout + 1'b1;
        end
    end

    // Address generation and registered VRAM writes. The pixel write uses
    // the current {y, x}. The line update comes later in this block, so it
    // wins on x when both edges arrive in the same cycle.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            r_x            <= '0;
            r_y            <= '0;
            r_inhibit      <= 1'b0;
            vram.vram_we   <= 1'b0;
            vram.vram_addr <= '0;
            vram.vram_data <= '0;
            frame_start    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            vram.vram_we <= 1'b0;
            frame_start  <= 1'b0;

            if (r_state == c_ST_WAIT_FRAME) begin
                if (w_hs_rise && w_vs) begin
                    r_x         <= '0;
                    r_y         <= '0;
                    r_inhibit   <= 1'b0;
                    frame_start <= 1'b1;
                    overrun     <= 1'b0;
                end
            end else begin
                if (w_pix_fall && !r_inhibit) begin
                    if (r_x < c_H_MAX) begin
                        vram.vram_we   <= 1'b1;
                        vram.vram_addr <= {r_y, r_x};
                        vram.vram_data <= w_pix;
                        r_x            <= r_x + 8'd1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end

                if (w_hs_rise) begin
                    r_x <= '0;
                    if (w_vs) begin
                        r_y         <= '0;
                        r_inhibit   <= 1'b0;
                        frame_start <= 1'b1;
                        overrun     <= 1'b0;
                    end else if (r_y < c_Y_LAST) begin
                        r_y <= r_y + 8'd1;
                    end else begin
                        // An extra line past the bottom of the frame: block writes until the next frame.
                        overrun   <= 1'b1;
                        r_inhibit <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmg_lcd_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmg_lcd_capture
// Description : Directed, scoreboard-based bench for dmg_lcd_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmg_lcd_capture;

    logic clk_8m    = 1'b0;
    logic rst       = 1'b1;
    logic lcd_clk   = 1'b0;
    logic lcd_hsync = 1'b0;
    logic lcd_vsync = 1'b0;
    logic lcd_d0    = 1'b0;
    logic lcd_d1    = 1'b0;
    logic frame_start;
    logic locked;
    logic overrun;

    dmg_lcd_capture_if vif ();

    dmg_lcd_capture #(
        .H_PIXELS       (160),
        .V_LINES        (144),
        .TIMEOUT_CYCLES (20000),
        .INVERT_DATA    (1'b0)
    ) dut (
        .clk_8m      (clk_8m),
        .rst         (rst),
        .lcd_clk     (lcd_clk),
        .lcd_hsync   (lcd_hsync),
        .lcd_vsync   (lcd_vsync),
        .lcd_d0      (lcd_d0),
        .lcd_d1      (lcd_d1),
        .vram        (vif.master),
        .frame_start (frame_start),
        .locked      (locked),
        .overrun     (overrun)
    );

    always #5 clk_8m = ~clk_8m;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_writes  = 0;
    int          n_fs      = 0;
    int          w_snap    = 0;
    logic [15:0] last_addr = 16'h0;
    logic [17:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] y, input logic [7:0] x, input logic [1:0] d);
        exp_q.push_back({y, x, d});
    endtask

    task automatic pix(input logic [1:0] d);
        @(negedge clk_8m);
        lcd_d1  = d[1];
        lcd_d0  = d[0];
        lcd_clk = 1'b1;
        @(negedge clk_8m);
        lcd_clk = 1'b0;
    endtask

    task automatic hs(input logic v);
        @(negedge clk_8m);
        lcd_vsync = v;
        lcd_hsync = 1'b1;
        @(negedge clk_8m);
        lcd_hsync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_8m);
    endtask

    // Scoreboard: every write strobe pops and compares the oldest expected write.
    always @(negedge clk_8m) begin
        if (vif.vram_we === 1'b1) begin
            n_writes++;
            last_addr = vif.vram_addr;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(vif.vram_addr), 32'h1_0000);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(vif.vram_addr), 32'(e[17:2]));
                check("wr_data", 32'(vif.vram_data), 32'(e[1:0]));
            end
        end
        if (frame_start === 1'b1) n_fs++;
    end

    initial begin
        // Reset state
        idle(3);
        check("rst_we",     32'(vif.vram_we),   32'd0);
        check("rst_addr",   32'(vif.vram_addr), 32'd0);
        check("rst_data",   32'(vif.vram_data), 32'd0);
        check("rst_fs",     32'(frame_start),   32'd0);
        check("rst_locked", 32'(locked),        32'd0);
        check("rst_ovr",    32'(overrun),       32'd0);
        @(negedge clk_8m);
        rst = 1'b0;
        idle(2);

        // Pixels and a plain hsync while unlocked: no writes
        for (int i = 0; i < 10; i++) pix(2'(i));
        hs(1'b0);
        idle(6);
        check("unlocked_writes", 32'(n_writes), 32'd0);
        check("unlocked_locked", 32'(locked),   32'd0);

        // Frame start latency: pulse appears exactly 3 cycles after the hsync edge
        @(negedge clk_8m);
        lcd_vsync = 1'b1;
        lcd_hsync = 1'b1;
        idle(2);
        check("fs_early", 32'(frame_start), 32'd0);
        idle(1);
        check("fs_latency", 32'(frame_start), 32'd1);
        check("fs_locked",  32'(locked),      32'd1);
        lcd_hsync = 1'b0;
        idle(1);
        check("fs_one_cycle", 32'(frame_start), 32'd0);
        check("fs_count1",    32'(n_fs),        32'd1);

        // Full 144 x 160 frame, data = x[1:0]
        for (int y = 0; y < 144; y++) begin
            for (int x = 0; x < 160; x++) begin
                push(8'(y), 8'(x), 2'(x));
                pix(2'(x));
            end
            if (y != 143) hs(1'b0);
        end
        idle(6);
        check("frame_writes", 32'(n_writes),  32'd23040);
        check("frame_last",   32'(last_addr), 32'h8F9F);
        check("frame_ovr",    32'(overrun),   32'd0);

        // 145th line: overrun, writes inhibited
        hs(1'b0);
        idle(4);
        check("line145_ovr", 32'(overrun), 32'd1);
        for (int i = 0; i < 3; i++) pix(2'd3);
        idle(6);
        check("line145_nowr", 32'(n_writes), 32'd23040);

        // Next frame start clears overrun
        hs(1'b1);
        idle(4);
        check("frame2_ovr", 32'(overrun), 32'd0);
        check("fs_count2",  32'(n_fs),    32'd2);

        // 161st pixel on a line
        for (int x = 0; x < 160; x++) begin
            push(8'd0, 8'(x), 2'(x + 1));
            pix(2'(x + 1));
        end
        pix(2'd2);
        idle(6);
        check("px161_ovr",  32'(overrun),  32'd1);
        check("px161_nowr", 32'(n_writes), 32'd23200);
        hs(1'b0);
        push(8'd1, 8'd0, 2'd2);
        pix(2'd2);
        idle(6);
        check("ovr_sticky", 32'(overrun),   32'd1);
        check("line1_addr", 32'(last_addr), 32'h0100);
        hs(1'b1);
        idle(4);
        check("frame3_ovr", 32'(overrun), 32'd0);
        check("fs_count3",  32'(n_fs),    32'd3);

        // Pixel fall and hsync rise in the same cycle at {y=5, x=10}
        for (int i = 0; i < 5; i++) hs(1'b0);
        for (int x = 0; x < 10; x++) begin
            push(8'd5, 8'(x), 2'(x));
            pix(2'(x));
        end
        push(8'd5, 8'd10, 2'd2);
        @(negedge clk_8m);
        lcd_d1  = 1'b1;
        lcd_d0  = 1'b0;
        lcd_clk = 1'b1;
        @(negedge clk_8m);
        lcd_clk   = 1'b0;
        lcd_vsync = 1'b0;
        lcd_hsync = 1'b1;
        @(negedge clk_8m);
        lcd_hsync = 1'b0;
        push(8'd6, 8'd0, 2'd1);
        pix(2'd1);
        idle(6);
        check("same_cycle_last", 32'(last_addr),    32'h0600);
        check("same_cycle_q",    32'(exp_q.size()), 32'd0);

        // Hsync watchdog
        idle(19000);
        check("to_still_locked", 32'(locked), 32'd1);
        idle(1100);
        check("to_unlocked", 32'(locked), 32'd0);
        w_snap = n_writes;
        for (int i = 0; i < 3; i++) pix(2'd1);
        hs(1'b0);
        pix(2'd2);
        idle(6);
        check("to_nowr",   32'(n_writes), 32'(w_snap));
        check("to_locked", 32'(locked),   32'd0);
        hs(1'b1);
        push(8'd0, 8'd0, 2'd3);
        pix(2'd3);
        push(8'd0, 8'd1, 2'd1);
        pix(2'd1);
        idle(6);
        check("relock", 32'(locked), 32'd1);

        // Reset mid-line aborts the pending write
        pix(2'd0);
        @(negedge clk_8m);
        rst = 1'b1;
        idle(3);
        check("mrst_we",     32'(vif.vram_we), 32'd0);
        check("mrst_locked", 32'(locked),      32'd0);
        check("mrst_addr",   32'(vif.vram_addr), 32'd0);
        rst = 1'b0;
        w_snap = n_writes;
        for (int i = 0; i < 3; i++) pix(2'd1);
        hs(1'b0);
        pix(2'd3);
        pix(2'd2);
        idle(6);
        check("mrst_nowr",   32'(n_writes), 32'(w_snap));
        check("mrst_unlock", 32'(locked),   32'd0);
        hs(1'b1);
        push(8'd0, 8'd0, 2'd2);
        pix(2'd2);
        idle(6);
        check("mrst_relock_addr", 32'(last_addr),    32'h0000);
        check("final_queue",      32'(exp_q.size()), 32'd0);
        check("fs_total",         32'(n_fs),         32'd5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
